// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO drain serializer.
// Build option: FIFO_SER_PARITY_EN adds an even-parity bit after the data bits.
package fifo_ser_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPop,
    StLoad,
    StStart,
    StData,
`ifdef FIFO_SER_PARITY_EN
    StParity,
`endif
    StStop
  } ser_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

`ifdef FIFO_SER_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame length in clock cycles: start + data + optional parity + stop.
  function automatic int unsigned frame_cycles(input int unsigned data_w,
                                               input int unsigned bit_cycles,
                                               input bit          parity);
    return (2 + data_w + (parity ? 1 : 0)) * bit_cycles;
  endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit-period timer: counts BIT_CYCLES clocks per serial bit and flags the last one.
module ser_bit_timer #(
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_i,
  input  logic clear_i,
  output logic bit_end_o,
  output logic bit_end_next_o
);

  localparam int unsigned   CW   = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear on state entry, otherwise count and wrap at the terminal count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end_o      = (cnt_q == LAST);
  // Lets the parent register an output that must line up with the final cycle of a bit.
  assign bit_end_next_o = (cnt_d == LAST);

endmodule

// File: rtl/fifo_drain_serializer.sv
// Pops words from a synchronous FIFO and shifts each out as a serial frame:
// start bit, data LSB first, optional even parity, stop bit.
// Build option: FIFO_SER_PARITY_EN compiles in the parity state and accumulator.
module fifo_drain_serializer
  import fifo_ser_pkg::*;
#(
  parameter int unsigned DATA_W     = 3,
  parameter int unsigned BIT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              empty_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rd_en_o,
  output logic              ser_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int unsigned   BW       = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              rd_en_q, rd_en_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              bit_end, bit_end_next;
`ifdef FIFO_SER_PARITY_EN
  logic              par_q, par_d;
`endif

  ser_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_timer (
    .clk           (clk),
    .reset_i       (reset_i),
    .clear_i       (state_d != state_q),
    .bit_end_o     (bit_end),
    .bit_end_next_o(bit_end_next)
  );

  // Next state, datapath updates, and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef FIFO_SER_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      StIdle:  if (!empty_i) state_d = StPop;
      StPop:   state_d = StLoad;
      StLoad: begin
        shift_d = data_i;
`ifdef FIFO_SER_PARITY_EN
        par_d   = 1'b0;
`endif
        state_d = StStart;
      end
      StStart: if (bit_end) state_d = StData;
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
`ifdef FIFO_SER_PARITY_EN
          par_d   = par_q ^ shift_q[0];
`endif
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef FIFO_SER_PARITY_EN
            state_d   = StParity;
`else
            state_d   = StStop;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef FIFO_SER_PARITY_EN
      StParity: if (bit_end) state_d = StStop;
`endif
      StStop:  if (bit_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Outputs are decoded from the next state so they can be registered.
    rd_en_d = (state_d == StPop);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StStop) && bit_end_next;
    case (state_d)
      StStart:  ser_d = START_BIT;
      StData:   ser_d = shift_d[0];
`ifdef FIFO_SER_PARITY_EN
      StParity: ser_d = par_d;
`endif
      StStop:   ser_d = STOP_BIT;
      default:  ser_d = LINE_IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rd_en_q   <= 1'b0;
      ser_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_SER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rd_en_q   <= rd_en_d;
      ser_q     <= ser_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FIFO_SER_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign rd_en_o      = rd_en_q;
  assign ser_o        = ser_q;
  assign busy_o       = busy_q;
  assign frame_done_o = done_q;

endmodule

// File: doc/fifo_drain_serializer.md
# fifo_drain_serializer

Downstream consumer of the synchronous FIFO: pops one word whenever the FIFO is non-empty and shifts it out as an asynchronous-style serial frame (start bit, data LSB-first, optional parity, stop bit). Its `rd_en_o`, `empty_i` and `data_i` connect directly to the FIFO's `rd_en_i`, `empty_o` and `data_o`. Throughput is set by a per-bit clock-cycle count, so the FIFO absorbs write bursts while this block drains at line rate.

## Interface
- `DATA_W`, default 3: word width; must match the FIFO data width.
- `BIT_CYCLES`, default 4: clock cycles per serial bit; legal range ≥1.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `reset_i` input, 1 bit: asynchronous, active-low reset.
- `empty_i` input, 1 bit: FIFO empty flag.
- `data_i` input, DATA_W bits: FIFO read data, valid one cycle after `rd_en_o`.
- `rd_en_o` output, 1 bit: single-cycle pop request to the FIFO; registered.
- `ser_o` output, 1 bit: serial line; idles high.
- `busy_o` output, 1 bit: high in every state except IDLE.
- `frame_done_o` output, 1 bit: one-cycle pulse in the last cycle of the stop bit.

## Operation
- Reset values: `rd_en_o`=0, `ser_o`=1, `busy_o`=0, `frame_done_o`=0; state=IDLE; counters=0; shift register=0.
- FSM states: IDLE, POP, LOAD, START, DATA, [PARITY], STOP.
- IDLE: if `empty_i`=0, go to POP; otherwise stay. `ser_o`=1.
- POP: `rd_en_o`=1 for exactly this cycle, then go to LOAD. The FIFO presents the word during the next cycle.
- LOAD: capture `data_i` into the shift register and clear the parity accumulator. Go to START.
- START: `ser_o`=0 for BIT_CYCLES cycles.
- DATA: `ser_o`=shift[0] for each bit, LSB first. Shift right after each bit period. After DATA_W bits, go to PARITY or STOP.
- PARITY: `ser_o`=XOR of the data bits (even parity) for BIT_CYCLES cycles.
- STOP: `ser_o`=1 for BIT_CYCLES cycles. `frame_done_o`=1 in the final cycle. Then return to IDLE.
- `empty_i` is sampled only in IDLE. A FIFO that empties mid-frame does not affect the frame in progress.
- `rd_en_o` is never asserted while `empty_i`=1 was sampled; the block never underflows the FIFO.
- Reset assertion mid-frame: outputs return to reset values immediately and the frame is truncated. The popped word is lost, which is acceptable.
- Counter widths:
  - cycle counter: `$clog2(BIT_CYCLES)` bits, minimum 1;
  - bit counter: `$clog2(DATA_W+1)` bits.
- Counters wrap to 0 at terminal count. No arithmetic overflow is permitted.

## Timing
- Non-empty seen at edge k: POP in cycle k+1, LOAD in k+2, start bit begins at k+3.
- Frame length F = (2 + DATA_W + P) × BIT_CYCLES cycles, where P=1 with parity and 0 without.
- Back-to-back words: STOP → IDLE → POP → LOAD gives a 3-cycle idle-high gap between frames.
- Sustained drain rate: one word per F+3 cycles.
- All outputs are registered. No combinational path exists from inputs to outputs.

## Configuration
- Macro: `FIFO_SER_PARITY_EN`.
- Defined: the PARITY state is compiled in. An even-parity bit is inserted between the data bits and the stop bit, and F includes P=1.
- Undefined: the PARITY state, the parity accumulator and the related logic are absent. DATA goes directly to STOP and P=0.

## Structure
- Shared package `fifo_ser_pkg`:
  - state enum `ser_state_t`;
  - constants `LINE_IDLE`=1'b1, `START_BIT`=1'b0, `STOP_BIT`=1'b1;
  - function returning F for given DATA_W, BIT_CYCLES and parity.
- One sub-module, `ser_bit_timer`: counts BIT_CYCLES and emits a one-cycle `bit_end` tick. It is cleared on every state entry.
- Top level holds the FSM, shift register and parity accumulator.

## Test plan
- Reset held low for 10 cycles with `empty_i`=0 → `rd_en_o`=0 and `ser_o`=1 throughout. After release, the first `rd_en_o` pulse occurs exactly 1 cycle after the first sampling edge.
- Push the single word 3'b101 (DATA_W=3, BIT_CYCLES=4, no parity) → `ser_o` sequence 0,1,0,1,1, each bit held 4 cycles. `frame_done_o` pulses once at cycle 20 of the frame.
- FIFO filled with 0..7, then drained → 8 frames, each decoding to the values in order. Gaps between frames are exactly 3 cycles, `rd_en_o` pulses 8 times, and there is no pop after `empty_i` rises.
- With `FIFO_SER_PARITY_EN` and word 3'b011 → parity bit 0; with word 3'b111 → parity bit 1. Frame length is 24 cycles.
- Reset asserted in the middle of the DATA state → `ser_o`=1 and `busy_o`=0 in the same cycle. The next frame after release is correctly formed.
- BIT_CYCLES=1 → frame of 5 cycles with no skipped or duplicated bits.
